data_check: RTL and testbench

Receive-side frame checker for the SSD test datapath. It drains the FIFO that the test-pattern source fills, hunts for the 32-bit sync word and locks to 1024-byte frames. It then verifies the big-endian 32-bit frame counter and the index-derived payload, and keeps saturating error and good-frame statistics for readback.

---
 rtl/ssd_frame_pkg.sv | 25 ++
 rtl/sat_counter.sv | 25 ++
 rtl/data_check.sv | 159 +++++++++++++++
 tb/tb_data_check.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ssd_frame_pkg.sv
// Shared constants and types for the SSD test-pattern frame format.
// The pattern source and the receive-side checker both import this package.
// Frame layout: 4-byte sync word (MSB byte first), 4-byte big-endian frame
// counter, then a payload whose byte at index i is i[7:0].
package ssd_frame_pkg;

  localparam int          FRAME_LEN_DEF = 1024;
  localparam logic [31:0] SYNC_WORD_DEF = 32'h1ACFFC1D;
  localparam int          HDR_LEN       = 8;

  typedef enum logic [1:0] {HUNT, SYNC, HEADER, PAYLOAD} state_e;

  // Byte i of the sync word in transmit order (i = 0 is the MSB byte).
  function automatic logic [7:0] sync_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] r;
    case (i)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the frame checker statistics.
// Ports:
//   clk   in   clock
//   nRST  in   synchronous active-low reset (clears to 0)
//   inc   in   count enable, one increment per cycle
//   q     out  count value, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!nRST)                   cnt_q <= '0;
    else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign q = cnt_q;

endmodule

// File: rtl/data_check.sv
// Receive-side frame checker. Drains the pattern FIFO continuously, hunts for
// the sync word, locks to FRAME_LEN-byte frames, checks the frame counter for
// continuity and the payload against its index pattern, and keeps saturating
// statistics.
// Ports:
//   clk, nRST        clock, synchronous active-low reset
//   fifo_rdempty     FIFO empty flag
//   fifo_q           FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdreq       read request (= !fifo_rdempty)
//   locked           frame alignment held
//   frame_done       one-cycle pulse at the end of each locked frame
//   frame_good_cnt   clean frames (no sequence or payload error)
//   seq_err_cnt      frame-counter discontinuities
//   byte_err_cnt     mismatched payload bytes
//   sync_loss_cnt    losses of lock
//   last_frame_num   most recently received frame counter
module data_check
  import ssd_frame_pkg::*;
#(
  parameter int          FRAME_LEN = FRAME_LEN_DEF,
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        fifo_rdempty,
  input  logic [7:0]  fifo_q,
  output logic        fifo_rdreq,
  output logic        locked,
  output logic        frame_done,
  output logic [31:0] frame_good_cnt,
  output logic [15:0] seq_err_cnt,
  output logic [15:0] byte_err_cnt,
  output logic [15:0] sync_loss_cnt,
  output logic [31:0] last_frame_num
);

  localparam int             IW       = $clog2(FRAME_LEN);
  localparam logic [IW-1:0]  IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0]  IDX_HLST = IW'(HDR_LEN - 1);
  localparam logic [IW-1:0]  IDX_CNT0 = IW'(4);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q;
  logic [23:0]   hist_q;
  logic [23:0]   cnt_q;      // first three counter bytes while in HEADER
  logic          first_q;
  logic          frame_bad_q;
  logic          locked_q;
  logic          done_q;
  logic [31:0]   last_q;

  logic [7:0]    b;
  logic [31:0]   rx;
  logic          sync_hit, sync_miss;
  logic          acquire, hdr_end, seq_err, byte_err, frame_end, good_inc, sync_loss;

  assign fifo_rdreq = !fifo_rdempty;
  assign b          = fifo_q;
  assign rx         = {cnt_q, b};
  assign sync_hit   = ({hist_q, b} == SYNC_WORD);
  assign sync_miss  = (b != sync_byte(SYNC_WORD, idx_q[1:0]));

  // State register
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= HUNT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state; idx wraps from FRAME_LEN-1 to 0 by overflow (power of two).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (vld_q) begin
      case (state_q)
        HUNT: begin
          if (sync_hit) begin
            state_d = HEADER;
            idx_d   = IDX_CNT0;
          end
        end
        HEADER: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_HLST) state_d = PAYLOAD;
        end
        PAYLOAD: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = SYNC;
        end
        SYNC: begin
          if (sync_miss) begin
            state_d = HUNT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            if (idx_q[1:0] == 2'd3) state_d = HEADER;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-byte events that drive the datapath and statistics.
  always_comb begin
    acquire   = vld_q && (state_q == HUNT) && sync_hit;
    hdr_end   = vld_q && (state_q == HEADER) && (idx_q == IDX_HLST);
    seq_err   = hdr_end && !first_q && (rx != 32'(last_q + 32'd1));
    byte_err  = vld_q && (state_q == PAYLOAD) && (b != 8'(idx_q));
    frame_end = vld_q && (state_q == PAYLOAD) && (idx_q == IDX_LAST);
    // byte_err is folded in so an error on the final byte still spoils the frame
    good_inc  = frame_end && !frame_bad_q && !byte_err;
    sync_loss = vld_q && (state_q == SYNC) && sync_miss;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      vld_q       <= 1'b0;
      hist_q      <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      frame_bad_q <= 1'b0;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= '0;
    end else begin
      vld_q  <= fifo_rdreq;
      done_q <= frame_end;
      if (vld_q) hist_q <= {hist_q[15:0], b};
      if (vld_q && state_q == HEADER) cnt_q <= {cnt_q[15:0], b};
      if (acquire) begin
        locked_q <= 1'b1;
        first_q  <= 1'b1;
      end
      if (sync_loss) locked_q <= 1'b0;
      if (hdr_end) begin
        last_q  <= rx;
        first_q <= 1'b0;
      end
      if (frame_end || sync_loss || acquire) frame_bad_q <= 1'b0;
      else if (seq_err || byte_err)          frame_bad_q <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(32)) u_good (.clk(clk), .nRST(nRST), .inc(good_inc),  .q(frame_good_cnt));
  sat_counter #(.WIDTH(16)) u_seq  (.clk(clk), .nRST(nRST), .inc(seq_err),   .q(seq_err_cnt));
  sat_counter #(.WIDTH(16)) u_byte (.clk(clk), .nRST(nRST), .inc(byte_err),  .q(byte_err_cnt));
  sat_counter #(.WIDTH(16)) u_loss (.clk(clk), .nRST(nRST), .inc(sync_loss), .q(sync_loss_cnt));

  assign locked         = locked_q;
  assign frame_done     = done_q;
  assign last_frame_num = last_q;

endmodule

// File: tb/tb_data_check.sv
module tb_data_check;

  localparam int FL = 1024;

  logic        clk = 1'b0;
  logic        nRST;
  logic        fifo_rdempty;
  logic [7:0]  fifo_q;
  logic        fifo_rdreq;
  logic        locked;
  logic        frame_done;
  logic [31:0] frame_good_cnt;
  logic [15:0] seq_err_cnt;
  logic [15:0] byte_err_cnt;
  logic [15:0] sync_loss_cnt;
  logic [31:0] last_frame_num;

  data_check dut (
    .clk(clk), .nRST(nRST), .fifo_rdempty(fifo_rdempty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .locked(locked), .frame_done(frame_done),
    .frame_good_cnt(frame_good_cnt), .seq_err_cnt(seq_err_cnt),
    .byte_err_cnt(byte_err_cnt), .sync_loss_cnt(sync_loss_cnt),
    .last_frame_num(last_frame_num)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         fails  = 0;
  int         done_cnt = 0;
  int         dbl_cnt  = 0;
  logic       prev_done = 1'b0;
  bit         gaps = 1'b0;
  logic [7:0] fr [0:FL-1];
  int         d0;

  // frame_done pulse counting; a pulse longer than one cycle bumps dbl_cnt
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      if (prev_done) dbl_cnt++;
    end
    prev_done = frame_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); fifo_rdempty = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // One FIFO read: request is sampled at the edge, data appears just after it.
  task automatic send(input logic [7:0] b);
    if (gaps && $urandom_range(1) == 1) idle(1);
    @(negedge clk); fifo_rdempty = 1'b0;
    @(posedge clk); #1; fifo_q = b;
  endtask

  task automatic build(input logic [31:0] cnt);
    for (int i = 0; i < FL; i++) fr[i] = 8'(i);
    fr[0] = 8'h1A; fr[1] = 8'hCF; fr[2] = 8'hFC; fr[3] = 8'h1D;
    fr[4] = cnt[31:24]; fr[5] = cnt[23:16]; fr[6] = cnt[15:8]; fr[7] = cnt[7:0];
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send(fr[i]);
  endtask

  task automatic send_frame(input logic [31:0] cnt);
    build(cnt);
    send_range(0, FL);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); nRST = 1'b0; fifo_rdempty = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".rdreq_lo"}, {31'd0, fifo_rdreq}, 32'd0);
    @(negedge clk); fifo_rdempty = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".rdreq_hi"}, {31'd0, fifo_rdreq}, 32'd1);
    chk({tag, ".locked"},   {31'd0, locked}, 32'd0);
    chk({tag, ".done"},     {31'd0, frame_done}, 32'd0);
    chk({tag, ".good"},     frame_good_cnt, 32'd0);
    chk({tag, ".seq"},      {16'd0, seq_err_cnt}, 32'd0);
    chk({tag, ".byte"},     {16'd0, byte_err_cnt}, 32'd0);
    chk({tag, ".loss"},     {16'd0, sync_loss_cnt}, 32'd0);
    chk({tag, ".last"},     last_frame_num, 32'd0);
    @(negedge clk); nRST = 1'b1; fifo_rdempty = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    nRST = 1'b0; fifo_rdempty = 1'b1; fifo_q = 8'h00;
    repeat (2) @(posedge clk);

    // 1: three clean back-to-back frames
    do_reset("t1rst");
    d0 = done_cnt;
    build(0);
    send_range(0, 4);
    chk("t1.lock_pre", {31'd0, locked}, 32'd0);
    send(fr[4]);
    chk("t1.lock_post", {31'd0, locked}, 32'd1);
    send_range(5, FL);
    chk("t1.done_pre", {31'd0, frame_done}, 32'd0);
    send_frame(1);
    send_frame(2);
    idle(2);
    chk("t1.done_n", done_cnt - d0, 32'd3);
    chk("t1.good",  frame_good_cnt, 32'd3);
    chk("t1.last",  last_frame_num, 32'd2);
    chk("t1.seq",   {16'd0, seq_err_cnt}, 32'd0);
    chk("t1.byte",  {16'd0, byte_err_cnt}, 32'd0);
    chk("t1.loss",  {16'd0, sync_loss_cnt}, 32'd0);

    // 2: garbage with a partial sync, then frame 9
    do_reset("t2rst");
    for (int i = 0; i < 16; i++) send(8'(i * 3 + 1));
    send(8'h1A); send(8'hCF); send(8'hFC); send(8'h00);
    for (int i = 0; i < 17; i++) send(8'(i + 64));
    idle(2);
    chk("t2.nolock", {31'd0, locked}, 32'd0);
    send_frame(9);
    idle(2);
    chk("t2.lock", {31'd0, locked}, 32'd1);
    chk("t2.good", frame_good_cnt, 32'd1);
    chk("t2.last", last_frame_num, 32'd9);
    chk("t2.loss", {16'd0, sync_loss_cnt}, 32'd0);

    // 3: sequence gap 5,7,8
    do_reset("t3rst");
    send_frame(5); send_frame(7); send_frame(8);
    idle(2);
    chk("t3.seq",  {16'd0, seq_err_cnt}, 32'd1);
    chk("t3.good", frame_good_cnt, 32'd2);
    chk("t3.last", last_frame_num, 32'd8);

    // 4: payload error mid-frame and on the final byte
    do_reset("t4rst");
    d0 = done_cnt;
    send_frame(2);
    build(3); fr[500] = 8'h00; send_range(0, FL);
    send_frame(4);
    build(5); fr[FL-1] = 8'h00; send_range(0, FL);
    idle(2);
    chk("t4.byte", {16'd0, byte_err_cnt}, 32'd2);
    chk("t4.good", frame_good_cnt, 32'd2);
    chk("t4.seq",  {16'd0, seq_err_cnt}, 32'd0);
    chk("t4.done_n", done_cnt - d0, 32'd4);

    // 5: corrupted sync on frame 2, relock on frame 3
    do_reset("t5rst");
    d0 = done_cnt;
    send_frame(1);
    build(2); fr[2] = 8'h00;
    send_range(0, 4);
    chk("t5.unlock", {31'd0, locked}, 32'd0);
    send_range(4, FL);
    chk("t5.still_unlock", {31'd0, locked}, 32'd0);
    send_frame(3); send_frame(4);
    idle(2);
    chk("t5.loss", {16'd0, sync_loss_cnt}, 32'd1);
    chk("t5.seq",  {16'd0, seq_err_cnt}, 32'd0);
    chk("t5.good", frame_good_cnt, 32'd3);
    chk("t5.last", last_frame_num, 32'd4);
    chk("t5.lock", {31'd0, locked}, 32'd1);
    chk("t5.done_n", done_cnt - d0, 32'd3);

    // 6: random gaps, reset in the middle of frame 2
    do_reset("t6rst");
    gaps = 1'b1;
    send_frame(0); send_frame(1);
    idle(2);
    chk("t6.good_a", frame_good_cnt, 32'd2);
    chk("t6.last_a", last_frame_num, 32'd1);
    chk("t6.seq_a",  {16'd0, seq_err_cnt}, 32'd0);
    build(2); send_range(0, 300);
    do_reset("t6mid");
    send_frame(3); send_frame(4);
    idle(2);
    gaps = 1'b0;
    chk("t6.good_b", frame_good_cnt, 32'd2);
    chk("t6.last_b", last_frame_num, 32'd4);
    chk("t6.seq_b",  {16'd0, seq_err_cnt}, 32'd0);
    chk("t6.byte_b", {16'd0, byte_err_cnt}, 32'd0);
    chk("t6.lock_b", {31'd0, locked}, 32'd1);

    chk("done.width", dbl_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
